note_recorder: RTL and testbench
================================

# note_recorder

Record/playback stage between the keyboard sound-select logic and `buzzer_Ctrl`. In idle and record modes it passes the selected note divider straight through to the buzzer. While recording, it also logs each held note and how long it was held. In playback it drives the buzzer from the log, replaying the captured melody once with its original timing.

## Interface
- `DEPTH`, 64: number of log entries.
- `TICK_DIV`, 1_000_000: clk cycles per duration tick (10 ms at 100 MHz).
- `DUR_W`, 8: duration field width in ticks (max 255).
- `clk` input 1: crystal clock; the only clock.
- `rst` input 1: synchronous, active-high reset.
- `note_in` input 22: note divider from sound select; 0 = silence.
- `rec_start` input 1: one-cycle pulse, start recording.
- `play_start` input 1: one-cycle pulse, start playback.
- `stop` input 1: one-cycle pulse, abort the current mode.
- `note_out` output 22: registered note divider to `buzzer_Ctrl`.
- `mode` output 2: 0 IDLE, 1 REC, 2 PLAY (registered).
- `count` output log2(DEPTH)+1: number of valid log entries.
- `full` output 1: log filled during the last recording.

## Operation
- Reset values:
  - `mode`=IDLE, `count`=0, `full`=0, `note_out`=0.
  - Tick counter, duration counter, play address and remaining counter all 0.
  - Log contents are not reset.
- Command priority in the same cycle: `stop` > `rec_start` > `play_start`.
- Tick generator: free-running, 0..TICK_DIV-1. `tick` is high for one cycle at TICK_DIV-1. The counter clears on every mode transition.
- IDLE:
  - `note_out` <= `note_in`.
  - `rec_start` -> REC. On entry: `count`<=0, `full`<=0, `cur_note`<=`note_in`, `dur`<=0.
  - `play_start` with `count`>0 -> PLAY. On entry: `addr`<=0, `note_out`<=log[0].note, `remain`<=log[0].dur.
  - `play_start` with `count`==0 is ignored. `stop` in IDLE is a no-op.
- REC:
  - `note_out` <= `note_in` (passthrough).
  - On `tick`: `dur`<=`dur`+1.
  - Segment close: `note_in`≠`cur_note`, or `tick` with `dur`==2^DUR_W-1.
    - If `dur`>0: write {cur_note, dur(+1 if this cycle's tick)} to log[`count`] and increment `count`.
    - If `dur`==0 with no tick (glitch shorter than one tick): nothing is written.
    - In both cases: `cur_note`<=`note_in`, `dur`<=0.
  - Saturation: a note held longer than 255 ticks is split into consecutive entries of the same note.
  - If a write makes `count`==DEPTH: `full`<=1, -> IDLE.
  - `stop`: flush the open segment if `dur`>0 (written exactly as a segment close), then -> IDLE.
  - `rec_start` and `play_start` are ignored.
- PLAY:
  - `note_out` holds log[`addr`].note.
  - On `tick`: `remain`<=`remain`-1.
  - On `tick` with `remain`==1:
    - If `addr`==`count`-1: -> IDLE, and `note_out` resumes passthrough.
    - Otherwise: `addr`++, load the next note and duration.
  - `stop`: -> IDLE immediately.
  - `rec_start` and `play_start` are ignored.
  - `note_in` is ignored while playing.
- Silence (`note_in`==0) is recorded and replayed like any other note.
- Arithmetic:
  - `dur` and `remain` are DUR_W-bit unsigned.
  - `count` has one extra bit so that DEPTH is representable.
  - The address wraps never: REC stops at full, and PLAY stops at `count`-1.

## Timing
- Every output is registered.
- Passthrough latency is 1 cycle: `note_out` at cycle n+1 equals `note_in` at cycle n.
- Command accepted at cycle n: `mode` changes at n+1.
- PLAY, first note: `note_out` equals log[0].note at n+1.
- PLAY, advance: on the final tick at cycle t, `note_out` shows the next note at t+1.
- Each replayed entry lasts exactly dur×TICK_DIV cycles, ±0 cycles.
- Log write on segment close: the new `count` is visible the next cycle.
- Reset asserted mid-REC or mid-PLAY returns every output to its reset value on the next edge. The stored log is retained but invalid, because `count`=0.

## Test plan
All scenarios use TICK_DIV=4, DEPTH=4.
- Reset, then `note_in`=22'd191571 -> `note_out`=191571 one cycle later; `mode`=0, `count`=0.
- REC; hold A for 3 ticks, B for 2 ticks, then `stop` -> `count`=2; log = {A,3},{B,2}; `mode`=0.
- `play_start` after the previous scenario -> `mode`=2 next cycle; `note_out`=A for 12 cycles, then B for 8 cycles; then `mode`=0 and passthrough resumes.
- REC with 5 distinct notes of 1 tick each -> the 4th write sets `full`=1 and `mode`=0; `count`=4; the 5th note is not logged.
- Note change within 2 cycles of entering REC (before any tick) -> no entry written; the first logged entry is the new note.
- Edge cases:
  - `stop` and `rec_start` in the same cycle during PLAY -> IDLE, with no recording started.
  - `play_start` with `count`=0 -> `mode` stays 0.

Source files
------------

// File: rtl/note_recorder.sv
// Record/playback stage between keyboard sound select and buzzer_Ctrl: passes notes through, logs held notes with durations in REC, replays the log in PLAY.
// Latency: 1 cycle for passthrough and for every command; all outputs registered.
// Backpressure: none; command inputs are single-cycle pulses with priority stop > rec_start > play_start.
//
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_note_in         : note divider from sound select (0 = silence)
//   i_rec_start       : pulse, start recording (from IDLE)
//   i_play_start      : pulse, start playback (from IDLE, only when log non-empty)
//   i_stop            : pulse, abort the current mode
//   o_note_out        : note divider to the buzzer
//   o_mode            : 0 IDLE, 1 REC, 2 PLAY
//   o_count           : number of valid log entries
//   o_full            : log filled during the last recording
module note_recorder #(
  parameter int DEPTH    = 64,
  parameter int TICK_DIV = 1_000_000,
  parameter int DUR_W    = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [21:0]              i_note_in,
  input  logic                     i_rec_start,
  input  logic                     i_play_start,
  input  logic                     i_stop,
  output logic [21:0]              o_note_out,
  output logic [1:0]               o_mode,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = CW - 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REC  = 2'd1,
    S_PLAY = 2'd2
  } mode_t;

  typedef struct packed {
    logic [21:0]      note;
    logic [DUR_W-1:0] dur;
  } entry_t;

  // State
  mode_t            r_mode;
  logic [TW-1:0]    r_tick_cnt;
  logic [DUR_W-1:0] r_dur;
  logic [21:0]      r_cur_note;
  logic [AW-1:0]    r_addr;
  logic [DUR_W-1:0] r_remain;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic [21:0]      r_note_out;
  entry_t           r_log [DEPTH];

  // Next-state
  mode_t            w_mode_nxt;
  logic [TW-1:0]    w_tick_nxt;
  logic [DUR_W-1:0] w_dur_nxt;
  logic [21:0]      w_cur_note_nxt;
  logic [AW-1:0]    w_addr_nxt;
  logic [DUR_W-1:0] w_remain_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_full_nxt;
  logic [21:0]      w_note_out_nxt;
  logic             w_we;
  entry_t           w_wdat;

  logic             w_tick;
  logic             w_close;
  logic [DUR_W:0]   w_dur_eff;
  logic [DUR_W-1:0] w_wr_dur;
  logic [AW-1:0]    w_addr_inc;

  assign w_tick     = (r_tick_cnt == TW'(TICK_DIV - 1));
  // Duration of the open segment including a tick landing on the closing cycle.
  assign w_dur_eff  = {1'b0, r_dur} + {{DUR_W{1'b0}}, w_tick};
  // A tick arriving at the cap would overflow the field; the entry is clamped.
  assign w_wr_dur   = w_dur_eff[DUR_W] ? {DUR_W{1'b1}} : w_dur_eff[DUR_W-1:0];
  assign w_close    = (i_note_in != r_cur_note) || (w_tick && (r_dur == {DUR_W{1'b1}}));
  assign w_addr_inc = r_addr + AW'(1);

  always_comb begin
    w_mode_nxt     = r_mode;
    w_dur_nxt      = r_dur;
    w_cur_note_nxt = r_cur_note;
    w_addr_nxt     = r_addr;
    w_remain_nxt   = r_remain;
    w_count_nxt    = r_count;
    w_full_nxt     = r_full;
    w_note_out_nxt = r_note_out;
    w_we           = 1'b0;
    w_wdat         = '0;
    w_tick_nxt     = '0;

    case (r_mode)
      S_IDLE: begin
        w_note_out_nxt = i_note_in;
        // stop outranks the other commands even though it does nothing here
        if (!i_stop) begin
          if (i_rec_start) begin
            w_mode_nxt     = S_REC;
            w_count_nxt    = '0;
            w_full_nxt     = 1'b0;
            w_cur_note_nxt = i_note_in;
            w_dur_nxt      = '0;
          end else if (i_play_start && (r_count != '0)) begin
            w_mode_nxt     = S_PLAY;
            w_addr_nxt     = '0;
            w_note_out_nxt = r_log[0].note;
            w_remain_nxt   = r_log[0].dur;
          end
        end
      end

      S_REC: begin
        w_note_out_nxt = i_note_in;
        if (w_tick) begin
          w_dur_nxt = r_dur + DUR_W'(1);
        end
        // stop flushes the open segment exactly like a note change would
        if (w_close || i_stop) begin
          if (w_dur_eff != '0) begin
            w_we        = 1'b1;
            w_wdat      = '{note: r_cur_note, dur: w_wr_dur};
            w_count_nxt = r_count + CW'(1);
            if (r_count == CW'(DEPTH - 1)) begin
              w_full_nxt = 1'b1;
              w_mode_nxt = S_IDLE;
            end
          end
          w_cur_note_nxt = i_note_in;
          w_dur_nxt      = '0;
        end
        if (i_stop) begin
          w_mode_nxt = S_IDLE;
        end
      end

      S_PLAY: begin
        if (i_stop) begin
          w_mode_nxt     = S_IDLE;
          w_note_out_nxt = i_note_in;
        end else if (w_tick) begin
          w_remain_nxt = r_remain - DUR_W'(1);
          if (r_remain == DUR_W'(1)) begin
            if ({1'b0, r_addr} == (r_count - CW'(1))) begin
              w_mode_nxt     = S_IDLE;
              w_note_out_nxt = i_note_in;
            end else begin
              w_addr_nxt     = w_addr_inc;
              w_note_out_nxt = r_log[w_addr_inc].note;
              w_remain_nxt   = r_log[w_addr_inc].dur;
            end
          end
        end
      end

      default: begin
        w_mode_nxt = S_IDLE;
      end
    endcase

    // Tick phase restarts at every mode change so durations align to mode entry.
    if ((w_mode_nxt != r_mode) || w_tick) begin
      w_tick_nxt = '0;
    end else begin
      w_tick_nxt = r_tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode     <= S_IDLE;
      r_tick_cnt <= '0;
      r_dur      <= '0;
      r_cur_note <= '0;
      r_addr     <= '0;
      r_remain   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_note_out <= '0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_dur      <= w_dur_nxt;
      r_cur_note <= w_cur_note_nxt;
      r_addr     <= w_addr_nxt;
      r_remain   <= w_remain_nxt;
      r_count    <= w_count_nxt;
      r_full     <= w_full_nxt;
      r_note_out <= w_note_out_nxt;
    end
  end

  // Log storage carries no reset; o_count alone defines what is valid.
  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_log[r_count[AW-1:0]] <= w_wdat;
    end
  end

  assign o_note_out = r_note_out;
  assign o_mode     = r_mode;
  assign o_count    = r_count;
  assign o_full     = r_full;

endmodule

// File: tb/tb_note_recorder.sv
module tb_note_recorder;
  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 8;
  localparam int CW       = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [21:0]   note_in;
  logic          rec_start, play_start, stop;
  logic [21:0]   note_out;
  logic [1:0]    mode;
  logic [CW-1:0] count;
  logic          full;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  note_recorder #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .DUR_W(DUR_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_note_in(note_in), .i_rec_start(rec_start),
    .i_play_start(play_start), .i_stop(stop), .o_note_out(note_out),
    .o_mode(mode), .o_count(count), .o_full(full)
  );

  typedef struct {
    logic [21:0] note;
    int          dur;
  } ent_t;

  typedef struct {
    logic        rec, play, stp;
    logic [21:0] note;
    logic [1:0]  exp_mode;
    logic [21:0] exp_note;
    int          exp_count;
  } vec_t;

  ent_t exp_q[$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [21:0] pick();
    case ($urandom_range(0, 3))
      0:       return 22'd0;
      1:       return 22'd191571;
      2:       return 22'd95556;
      default: return 22'd113636;
    endcase
  endfunction

  // Replays the log and checks every cycle against the expected entries in exp_q.
  task automatic play_check(input string tag);
    logic [21:0] last;
    last       = 22'd7;
    note_in    = last;
    play_start = 1'b1;
    cyc();
    play_start = 1'b0;
    foreach (exp_q[i]) begin
      for (int k = 0; k < exp_q[i].dur * TICK_DIV; k++) begin
        chk({tag, " play mode"}, 32'(mode), 32'd2);
        chk({tag, " play note"}, 32'(note_out), 32'(exp_q[i].note));
        last    = 22'($urandom);
        note_in = last;
        cyc();
      end
    end
    chk({tag, " end mode"}, 32'(mode), 32'd0);
    chk({tag, " end passthrough"}, 32'(note_out), 32'(last));
  endtask

  initial begin
    vec_t        vecs[5];
    logic [21:0] nts[5];
    logic [21:0] seq[$];
    logic [21:0] cur, nt;
    int          ticks, len, nseg, last_c;
    bit          done;

    rst = 1'b1; note_in = 22'd55; rec_start = 1'b0; play_start = 1'b0; stop = 1'b0;
    cyc(); cyc();
    chk("reset note_out", 32'(note_out), 32'd0);
    chk("reset mode", 32'(mode), 32'd0);
    chk("reset count", 32'(count), 32'd0);
    chk("reset full", 32'(full), 32'd0);
    rst = 1'b0;

    // IDLE passthrough and ignored commands
    vecs[0] = '{1'b0, 1'b0, 1'b0, 22'd191571,   2'd0, 22'd191571,   0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 22'd5,        2'd0, 22'd5,        0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 22'd0,        2'd0, 22'd0,        0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 22'h3FFFFF,   2'd0, 22'h3FFFFF,   0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 22'd12345,    2'd0, 22'd12345,    0};
    for (int i = 0; i < 5; i++) begin
      rec_start = vecs[i].rec; play_start = vecs[i].play; stop = vecs[i].stp;
      note_in   = vecs[i].note;
      cyc();
      chk($sformatf("vec%0d mode", i), 32'(mode), 32'(vecs[i].exp_mode));
      chk($sformatf("vec%0d note_out", i), 32'(note_out), 32'(vecs[i].exp_note));
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
    end
    rec_start = 1'b0; play_start = 1'b0; stop = 1'b0;

    // A for 3 ticks, B for 2 ticks, stop
    rec_start = 1'b1; note_in = 22'd191571; cyc(); rec_start = 1'b0;
    chk("rec2 mode", 32'(mode), 32'd1);
    for (int c = 1; c <= 21; c++) begin
      note_in = (c <= 12) ? 22'd191571 : 22'd95556;
      stop    = (c == 21);
      cyc();
      if (c == 13) chk("rec2 count after A", 32'(count), 32'd1);
    end
    stop = 1'b0;
    chk("rec2 count", 32'(count), 32'd2);
    chk("rec2 mode idle", 32'(mode), 32'd0);
    chk("rec2 full", 32'(full), 32'd0);
    exp_q = {};
    exp_q.push_back('{22'd191571, 3});
    exp_q.push_back('{22'd95556, 2});
    play_check("ab");

    // five one-tick notes: the fourth write fills the log
    nts[0] = 22'd11; nts[1] = 22'd22; nts[2] = 22'd33; nts[3] = 22'd44; nts[4] = 22'd55;
    rec_start = 1'b1; note_in = nts[0]; cyc(); rec_start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      note_in = nts[(c - 1) / 4];
      cyc();
      if (c == 16) begin
        chk("full pre count", 32'(count), 32'd3);
        chk("full pre mode", 32'(mode), 32'd1);
      end
    end
    chk("full flag", 32'(full), 32'd1);
    chk("full mode", 32'(mode), 32'd0);
    chk("full count", 32'(count), 32'd4);
    cyc();
    chk("full count hold", 32'(count), 32'd4);
    exp_q = {};
    for (int i = 0; i < 4; i++) exp_q.push_back('{nts[i], 1});
    play_check("full");

    // note change before the first tick leaves no entry
    rec_start = 1'b1; note_in = 22'd300; cyc(); rec_start = 1'b0;
    note_in = 22'd300; cyc();
    note_in = 22'd400; cyc();
    chk("glitch count", 32'(count), 32'd0);
    for (int c = 3; c <= 9; c++) begin
      stop = (c == 9);
      cyc();
    end
    stop = 1'b0;
    chk("glitch final count", 32'(count), 32'd1);
    chk("glitch full cleared", 32'(full), 32'd0);
    exp_q = {};
    exp_q.push_back('{22'd400, 2});
    play_check("glitch");

    // stop beats rec_start during PLAY
    play_start = 1'b1; cyc(); play_start = 1'b0;
    chk("stoprec play", 32'(mode), 32'd2);
    cyc();
    stop = 1'b1; rec_start = 1'b1; note_in = 22'd777; cyc();
    stop = 1'b0; rec_start = 1'b0;
    chk("stoprec mode", 32'(mode), 32'd0);
    chk("stoprec note", 32'(note_out), 32'd777);
    cyc();
    chk("stoprec stays idle", 32'(mode), 32'd0);
    chk("stoprec count kept", 32'(count), 32'd1);

    // randomized recordings checked by replay
    for (int it = 0; it < 8; it++) begin
      seq = {};
      seq.push_back(pick());
      nseg = $urandom_range(1, 6);
      for (int s = 0; s < nseg; s++) begin
        nt  = pick();
        len = $urandom_range(1, 12);
        for (int k = 0; k < len; k++) seq.push_back(nt);
      end
      last_c = seq.size() - 1;
      // run-length encode the held notes, counting ticks every TICK_DIV cycles from entry
      exp_q = {}; cur = seq[0]; ticks = 0; done = 1'b0;
      for (int c = 1; c <= last_c && !done; c++) begin
        if (c % TICK_DIV == 0) ticks++;
        if (seq[c] != cur || c == last_c) begin
          if (ticks > 0) exp_q.push_back('{cur, ticks});
          if (exp_q.size() == DEPTH) done = 1'b1;
          cur = seq[c]; ticks = 0;
        end
      end
      rec_start = 1'b1; note_in = seq[0]; cyc(); rec_start = 1'b0;
      for (int c = 1; c <= last_c; c++) begin
        note_in = seq[c]; stop = (c == last_c);
        cyc();
      end
      stop = 1'b0;
      chk($sformatf("rnd%0d count", it), 32'(count), 32'(exp_q.size()));
      chk($sformatf("rnd%0d full", it), 32'(full), 32'(exp_q.size() == DEPTH));
      chk($sformatf("rnd%0d mode", it), 32'(mode), 32'd0);
      if (exp_q.size() > 0) begin
        play_check($sformatf("rnd%0d", it));
      end else begin
        play_start = 1'b1; cyc(); play_start = 1'b0;
        chk($sformatf("rnd%0d empty play", it), 32'(mode), 32'd0);
      end
    end

    // reset in the middle of a recording
    rec_start = 1'b1; note_in = 22'd999; cyc(); rec_start = 1'b0;
    repeat (6) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("midrst mode", 32'(mode), 32'd0);
    chk("midrst count", 32'(count), 32'd0);
    chk("midrst note_out", 32'(note_out), 32'd0);
    chk("midrst full", 32'(full), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
